// File: rtl/sd_init_ctrl.sv
// sd_init_ctrl: SD card SPI-mode power-up and initialisation sequencer.
// Define SD_INIT_V1_SUPPORT_EN to accept v1 (pre-2.0) cards.
module sd_init_ctrl #(
  parameter int POWER_DELAY    = 1024,
  parameter int RESP_TIMEOUT   = 65535,
  parameter int ACMD41_RETRIES = 255,
  parameter int RETRY_GAP      = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic [5:0]  command,
  output logic [31:0] arg,
  output logic        cmd_valid,
  input  logic        command_sent,
  input  logic [39:0] response,
  input  logic        response_ready,
  output logic        fast_clk,
  output logic        busy,
  output logic        init_done,
  output logic        init_error,
  output logic [3:0]  err_code,
  output logic        high_capacity
);

  typedef enum logic [3:0] {
    IDLE, PWR_WAIT, CMD0, CMD8, CMD55, CMD41,
    GAP, CMD58, CMD16, DONE, ERROR
  } state_t;

  localparam logic [31:0] PWR_LAST = 32'(POWER_DELAY - 1);
  localparam logic [31:0] GAP_LAST = 32'(RETRY_GAP - 1);
  localparam logic [31:0] TO_LAST  = 32'(RESP_TIMEOUT - 1);
  localparam logic [15:0] TRY_MAX  = 16'(ACMD41_RETRIES);

  state_t      r_state, w_state;
  logic        r_wait, w_wait;
  logic [31:0] r_cnt, w_cnt;
  logic [15:0] r_tries, w_tries;
  logic        r_v2, w_v2;
  logic [5:0]  r_cmd, w_cmd;
  logic [31:0] r_arg, w_arg;
  logic        r_cv, w_cv;
  logic        r_fast, w_fast;
  logic        r_done, w_done;
  logic        r_err, w_err;
  logic [3:0]  r_code, w_code;
  logic        r_hc, w_hc;
  logic        w_acc;
  logic [3:0]  w_fail;
  logic [7:0]  w_r1;
  logic [5:0]  w_icmd;
  logic [31:0] w_iarg;
  logic        w_unused;

  assign w_r1     = response[39:32];
  assign w_unused = ^{response[31], response[29:12]};

  always_comb begin
    w_icmd = 6'd0;
    w_iarg = 32'd0;
    unique case (r_state)
      CMD8:    begin w_icmd = 6'd8;  w_iarg = 32'h0000_01AA; end
      CMD55:   w_icmd = 6'd55;
      CMD41:   begin
        w_icmd = 6'd41;
        w_iarg = r_v2 ? 32'h4000_0000 : 32'd0;
      end
      CMD58:   w_icmd = 6'd58;
      CMD16:   begin w_icmd = 6'd16; w_iarg = 32'd512; end
      default: ;
    endcase
  end

  always_comb begin
    w_state = r_state;
    w_wait  = r_wait;
    w_cnt   = r_cnt;
    w_tries = r_tries;
    w_v2    = r_v2;
    w_cmd   = r_cmd;
    w_arg   = r_arg;
    w_cv    = r_cv;
    w_fast  = r_fast;
    w_done  = r_done;
    w_err   = r_err;
    w_code  = r_code;
    w_hc    = r_hc;
    w_acc   = 1'b0;
    w_fail  = 4'd0;
    unique case (r_state)
      IDLE, DONE, ERROR: begin
        if (start) begin
          w_state = PWR_WAIT;
          w_wait  = 1'b0;
          w_cnt   = '0;
          w_tries = '0;
          w_v2    = 1'b0;
          w_fast  = 1'b0;
          w_done  = 1'b0;
          w_err   = 1'b0;
          w_code  = 4'd0;
          w_hc    = 1'b0;
        end
      end
      PWR_WAIT: begin
        w_cnt = r_cnt + 32'd1;
        if (r_cnt == PWR_LAST) begin
          w_state = CMD0;
          w_cnt   = '0;
        end
      end
      GAP: begin
        w_cnt = r_cnt + 32'd1;
        if (r_cnt == GAP_LAST) begin
          w_state = CMD55;
          w_cnt   = '0;
        end
      end
      default: begin
        if (!r_wait) begin
          if (!r_cv) begin
            w_cv  = 1'b1;
            w_cmd = w_icmd;
            w_arg = w_iarg;
          end else if (command_sent) begin
            w_cv   = 1'b0;
            w_wait = 1'b1;
            w_cnt  = '0;
            w_acc  = response_ready;
          end
        end else if (response_ready) begin
          w_acc = 1'b1;
        end else if (r_cnt == TO_LAST) begin
          w_fail = 4'd7;
        end else begin
          w_cnt = r_cnt + 32'd1;
        end
      end
    endcase

    if (w_acc) begin
      w_wait = 1'b0;
      unique case (r_state)
        CMD0: begin
          if (w_r1 == 8'h01) w_state = CMD8;
          else               w_fail  = 4'd1;
        end
        CMD8: begin
          if (w_r1 == 8'h01 && response[11:0] == 12'h1AA) begin
            w_v2    = 1'b1;
            w_state = CMD55;
          end else if (w_r1 == 8'h05) begin
`ifdef SD_INIT_V1_SUPPORT_EN
            w_v2    = 1'b0;
            w_state = CMD55;
`else
            w_fail  = 4'd8;
`endif
          end else begin
            w_fail = 4'd2;
          end
        end
        CMD55: begin
          if (w_r1 <= 8'h01) w_state = CMD41;
          else               w_fail  = 4'd3;
        end
        CMD41: begin
          if (w_r1 == 8'h00) begin
            w_state = r_v2 ? CMD58 : CMD16;
          end else if (w_r1 == 8'h01) begin
            if (r_tries != TRY_MAX) w_tries = r_tries + 16'd1;
            if (w_tries == TRY_MAX) begin
              w_fail = 4'd4;
            end else begin
              w_state = GAP;
              w_cnt   = '0;
            end
          end else begin
            w_fail = 4'd3;
          end
        end
        CMD58: begin
          if (w_r1 == 8'h00) begin
            w_hc    = response[30];
            w_state = response[30] ? DONE : CMD16;
          end else begin
            w_fail = 4'd5;
          end
        end
        CMD16: begin
          if (w_r1 == 8'h00) w_state = DONE;
          else               w_fail  = 4'd6;
        end
        default: ;
      endcase
    end

    if (w_fail != 4'd0) begin
      w_state = ERROR;
      w_wait  = 1'b0;
      w_code  = w_fail;
    end
    if (w_state == DONE) begin
      w_done = 1'b1;
      w_fast = 1'b1;
    end
    if (w_state == ERROR) begin
      w_err  = 1'b1;
      w_fast = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_wait  <= 1'b0;
      r_cnt   <= '0;
      r_tries <= '0;
      r_v2    <= 1'b0;
      r_cmd   <= '0;
      r_arg   <= '0;
      r_cv    <= 1'b0;
      r_fast  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      r_code  <= '0;
      r_hc    <= 1'b0;
    end else begin
      r_state <= w_state;
      r_wait  <= w_wait;
      r_cnt   <= w_cnt;
      r_tries <= w_tries;
      r_v2    <= w_v2;
      r_cmd   <= w_cmd;
      r_arg   <= w_arg;
      r_cv    <= w_cv;
      r_fast  <= w_fast;
      r_done  <= w_done;
      r_err   <= w_err;
      r_code  <= w_code;
      r_hc    <= w_hc;
    end
  end

  assign command       = r_cmd;
  assign arg           = r_arg;
  assign cmd_valid     = r_cv;
  assign fast_clk      = r_fast;
  assign init_done     = r_done;
  assign init_error    = r_err;
  assign err_code      = r_code;
  assign high_capacity = r_hc;
  assign busy = !(r_state == IDLE || r_state == DONE ||
                  r_state == ERROR);

endmodule

// File: tb/tb_sd_init_ctrl.sv
// tb_sd_init_ctrl: scoreboard bench with a scripted SD card responder.
// Expected commands are queued per scenario and popped on each handshake.
module tb_sd_init_ctrl;

  localparam int PD  = 8;
  localparam int TO  = 16;
  localparam int TRY = 3;
  localparam int GP  = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [5:0]  command;
  logic [31:0] arg;
  logic        cmd_valid;
  logic        command_sent;
  logic [39:0] response;
  logic        response_ready;
  logic        fast_clk;
  logic        busy;
  logic        init_done;
  logic        init_error;
  logic [3:0]  err_code;
  logic        high_capacity;

  always #5 clk = ~clk;

  sd_init_ctrl #(
    .POWER_DELAY(PD), .RESP_TIMEOUT(TO),
    .ACMD41_RETRIES(TRY), .RETRY_GAP(GP)
  ) dut (
    .clk(clk), .rst(rst), .start(start),
    .command(command), .arg(arg), .cmd_valid(cmd_valid),
    .command_sent(command_sent), .response(response),
    .response_ready(response_ready), .fast_clk(fast_clk),
    .busy(busy), .init_done(init_done), .init_error(init_error),
    .err_code(err_code), .high_capacity(high_capacity)
  );

  int          n_chk  = 0;
  int          n_fail = 0;
  logic [37:0] q_exp[$];
  logic [39:0] q_rsp[$];
  bit          same_cyc = 1'b0;
  time         t_sent = 0;

  task automatic check(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic ex(input logic [5:0] c, input logic [31:0] a);
    q_exp.push_back({c, a});
  endtask

  task automatic rs(input logic [7:0] r1, input logic [31:0] t);
    q_rsp.push_back({r1, t});
  endtask

  function automatic logic [7:0] st(input logic d, input logic e,
                                    input logic [3:0] c,
                                    input logic h, input logic f);
    return {d, e, c, h, f};
  endfunction

  function automatic logic [63:0] outs();
    return 64'({init_done, init_error, err_code,
                high_capacity, fast_clk});
  endfunction

  function automatic logic [63:0] all_outs();
    return 64'({command, arg, cmd_valid, fast_clk, busy,
                init_done, init_error, err_code, high_capacity});
  endfunction

  // Card responder: accepts each request, answers 3 cycles later
  initial begin
    int dly;
    dly = -1;
    command_sent   = 1'b0;
    response_ready = 1'b0;
    response       = '0;
    forever begin
      @(posedge clk);
      #1;
      command_sent   = 1'b0;
      response_ready = 1'b0;
      if (!rst) begin
        dly = -1;
      end else if (dly > 0) begin
        dly--;
      end else if (dly == 0) begin
        dly = -1;
        if (q_rsp.size() > 0) begin
          response       = q_rsp.pop_front();
          response_ready = 1'b1;
        end
      end else if (cmd_valid) begin
        command_sent = 1'b1;
        if (same_cyc && q_rsp.size() > 0) begin
          response       = q_rsp.pop_front();
          response_ready = 1'b1;
        end else begin
          dly = 2;
        end
      end
    end
  end

  // Monitor: pops the expected command on every handshake
  initial begin
    logic [37:0] e;
    forever begin
      @(negedge clk);
      if (rst && cmd_valid && command_sent) begin
        t_sent = $time + 5;
        if (q_exp.size() == 0) begin
          check("cmd_unexpected", 64'({command, arg}), 64'd0);
        end else begin
          e = q_exp.pop_front();
          check("cmd", 64'({command, arg}), 64'(e));
        end
      end
    end
  end

  task automatic run(input string nm);
    int i;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check({nm, "_start"}, 64'({busy, init_error, init_done, fast_clk}),
          64'h8);
    i = 0;
    while (busy && i < 1000) begin
      @(negedge clk);
      i++;
    end
    check({nm, "_idle"}, 64'(busy), 64'd0);
    check({nm, "_cmds_left"}, 64'(q_exp.size()), 64'd0);
  endtask

  task automatic sdhc_script();
    ex(6'd0, 32'd0);           rs(8'h01, 32'd0);
    ex(6'd8, 32'h1AA);         rs(8'h01, 32'h0000_01AA);
    ex(6'd55, 32'd0);          rs(8'h01, 32'd0);
    ex(6'd41, 32'h4000_0000);  rs(8'h01, 32'd0);
    ex(6'd55, 32'd0);          rs(8'h01, 32'd0);
    ex(6'd41, 32'h4000_0000);  rs(8'h01, 32'd0);
    ex(6'd55, 32'd0);          rs(8'h01, 32'd0);
    ex(6'd41, 32'h4000_0000);  rs(8'h00, 32'd0);
    ex(6'd58, 32'd0);          rs(8'h00, 32'hC0FF_8000);
  endtask

  initial begin
    int i;
    repeat (3) @(negedge clk);
    check("reset_outs", all_outs(), 64'd0);
    rst = 1'b1;

    sdhc_script();
    run("sdhc");
    check("sdhc_status", outs(), 64'(st(1, 0, 0, 1, 1)));

    same_cyc = 1'b1;
    ex(6'd0, 32'd0);           rs(8'h01, 32'd0);
    ex(6'd8, 32'h1AA);         rs(8'h01, 32'h0000_01AA);
    ex(6'd55, 32'd0);          rs(8'h00, 32'd0);
    ex(6'd41, 32'h4000_0000);  rs(8'h00, 32'd0);
    ex(6'd58, 32'd0);          rs(8'h00, 32'h80FF_8000);
    ex(6'd16, 32'h200);        rs(8'h00, 32'd0);
    run("sdsc");
    check("sdsc_status", outs(), 64'(st(1, 0, 0, 0, 1)));
    same_cyc = 1'b0;

    ex(6'd0, 32'd0);           rs(8'h01, 32'd0);
    ex(6'd8, 32'h1AA);         rs(8'h01, 32'h0000_01AB);
    run("bad_echo");
    check("bad_echo_status", outs(), 64'(st(0, 1, 2, 0, 0)));

    ex(6'd0, 32'd0);           rs(8'h01, 32'd0);
    ex(6'd8, 32'h1AA);         rs(8'h05, 32'd0);
`ifdef SD_INIT_V1_SUPPORT_EN
    ex(6'd55, 32'd0);          rs(8'h01, 32'd0);
    ex(6'd41, 32'd0);          rs(8'h00, 32'd0);
    ex(6'd16, 32'h200);        rs(8'h00, 32'd0);
    run("v1");
    check("v1_status", outs(), 64'(st(1, 0, 0, 0, 1)));
`else
    run("v1");
    check("v1_status", outs(), 64'(st(0, 1, 8, 0, 0)));
`endif

    ex(6'd0, 32'd0);           rs(8'h01, 32'd0);
    ex(6'd8, 32'h1AA);         rs(8'h01, 32'h0000_01AA);
    for (int k = 0; k < 3; k++) begin
      ex(6'd55, 32'd0);          rs(8'h01, 32'd0);
      ex(6'd41, 32'h4000_0000);  rs(8'h01, 32'd0);
    end
    run("retry");
    check("retry_status", outs(), 64'(st(0, 1, 4, 0, 0)));

    sdhc_script();
    run("rerun");
    check("rerun_status", outs(), 64'(st(1, 0, 0, 1, 1)));

    ex(6'd0, 32'd0);
    run("timeout");
    check("timeout_status", outs(), 64'(st(0, 1, 7, 0, 0)));
    check("timeout_cycles", 64'(($time - t_sent) / 10), 64'(TO));

    ex(6'd0, 32'd0);           rs(8'h01, 32'd0);
    ex(6'd8, 32'h1AA);         rs(8'h01, 32'h0000_01AA);
    ex(6'd55, 32'd0);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    i = 0;
    while (!(cmd_valid && command == 6'd55) && i < 500) begin
      @(negedge clk);
      i++;
    end
    check("rst_reached_cmd55", 64'({cmd_valid, command}),
          64'({1'b1, 6'd55}));
    #2;
    rst = 1'b0;
    #1;
    check("rst_async_outs", all_outs(), 64'd0);
    repeat (4) @(negedge clk);
    check("rst_held_outs", all_outs(), 64'd0);
    check("rst_cmds_left", 64'(q_exp.size()), 64'd0);
    q_exp.delete();
    q_rsp.delete();
    rst = 1'b1;
    repeat (4) @(negedge clk);
    check("post_rst_idle", all_outs(), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
